stage3_pipe_buffer: RTL and testbench
=====================================

# stage3_pipe_buffer

Parametrised elastic pipeline register for the stage3 pipeline. It carries one packed stage payload, such as a fetch-to-execute or execute-to-memory bundle, from a producer stage to a consumer stage using a valid/ready handshake. It holds up to DEPTH payloads in FIFO order, and a synchronous flush empties it when a branch is mispredicted or a trap is taken. With DEPTH=1 it is the classic single pipeline latch. Larger DEPTH values act as a skid/decoupling buffer, so the producer is not stalled combinationally by the consumer.

## Interface
Parameters:
- WIDTH, default 32: payload width in bits. Instantiations set it to the bit width of the stage struct.
- DEPTH, default 2: number of entries. Must be a power of two, and 1 ≤ DEPTH ≤ 16.

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  rising-edge clock.
- nRST  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  producer has a payload.
- in_data  input  WIDTH  producer payload.
- in_ready  output  1  buffer accepts a payload this cycle.
- out_valid  output  1  head entry is valid.
- out_data  output  WIDTH  head entry payload.
- out_ready  input  1  consumer takes the head this cycle. Low means stall/halt.
- count  output  $clog2(DEPTH+1)  number of occupied entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- State:
  - storage array mem[DEPTH] of WIDTH bits;
  - head and tail pointers, each max(1,$clog2(DEPTH)) bits;
  - count register.
- Pointer arithmetic is modulo DEPTH; pointers wrap naturally because DEPTH is a power of two. With DEPTH=1 both pointers stay at 0.
- Push: occurs when in_valid && in_ready. On the edge, mem[tail] ← in_data and tail ← tail+1.
- Pop: occurs when out_valid && out_ready. On the edge, head ← head+1.
- count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged when push and pop happen together.
- out_valid = !empty. out_data = mem[head], driven combinationally from the registered state.
- in_ready = !flush && (!full || out_ready). When the buffer is full, a same-cycle pop frees the slot for a push (pipe-through ready).
- Flush:
  - On an edge with flush=1: head, tail and count ← 0, whatever the handshakes were.
  - in_ready is low during the flush cycle, so no push occurs.
  - out_valid and out_data are not masked by flush; the consumer must qualify with its own flush.
  - Storage contents are not cleared by flush.
- Reset (nRST=0, asynchronous): head, tail and count ← 0, and every mem entry ← 0. Outputs while in reset and after release:
  - out_valid=0, out_data=0;
  - count=0, empty=1, full=0;
  - in_ready=!flush.
- No state machine beyond the pointers and count. The legal occupancy states are EMPTY (count=0), PARTIAL (0<count<DEPTH) and FULL (count=DEPTH). With DEPTH=1, PARTIAL does not exist.
- Overflow and underflow are impossible by construction: a push requires in_ready, and a pop requires out_valid. Producer-side in_data is ignored whenever in_valid=0.

## Timing
- Latency is 1 cycle: a payload pushed at edge N is visible on out_data/out_valid after edge N.
- Throughput is 1 payload per cycle sustained at any DEPTH, including DEPTH=1 when out_ready stays high.
- Combinational paths:
  - out_ready → in_ready;
  - flush → in_ready.
- There is no in_valid → out_valid path and no in_data → out_data path.
- count, full and empty are derived from registers only.
- Flush arriving during a stall: the buffer empties at the next edge, and out_valid=0 after that edge.
- Reset asserted mid-operation: state clears immediately, without waiting for CLK. Any payload in flight is lost.

## Test plan
- Reset: hold nRST=0 with in_valid=1 and in_data=32'hDEADBEEF. Required: out_valid=0, count=0, empty=1, out_data=0. Release nRST; the first push appears after 1 edge.
- Fill and stall (DEPTH=4): push 1, 2, 3, 4 with out_ready=0. Required: count reaches 4, full=1, in_ready=0. A fifth push of 5 is held off. Then set out_ready=1. Required: pops return 1, 2, 3, 4, 5 in order with pointer wrap.
- Simultaneous push and pop when full (DEPTH=4, holding 10..13): in_valid=1 with in_data=14, out_ready=1. Required: in_ready=1, count stays 4, and the next head is 11.
- Flush with contents (count=3): assert flush for 1 cycle with in_valid=1 and in_data=7. Required: in_ready=0 in that cycle; after the edge count=0, out_valid=0, and 7 is never output.
- DEPTH=1 streaming: push 100..109 on consecutive cycles with out_ready=1. Required: out_data shows 100..109, one per cycle, with no bubbles. With out_ready=0 for 2 cycles, 105 is held and in_ready=0.
- Asynchronous reset mid-stream (count=2): pulse nRST low between clock edges. Required: out_valid drops immediately and count=0, with no reappearance of the old data.

Source files
------------

// File: rtl/stage3_pipe_buffer.sv
// Elastic valid/ready pipeline register holding up to DEPTH payloads in FIFO order.
// Synchronous flush drops all entries; asynchronous active-low reset also zeroes storage.
module stage3_pipe_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             push;
   logic             pop;

   // Power-of-two depth lets pointers wrap on overflow; a single entry pins them at 0.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (DEPTH == 1) return '0;
      return p + PTR_W'(1);
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign out_valid = !empty;
   assign out_data  = mem[head];
   assign in_ready  = !flush && (!full || out_ready);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= in_data;
            tail      <= ptr_inc(tail);
         end
         if (pop) begin
            head <= ptr_inc(head);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_stage3_pipe_buffer.sv
// Bench for stage3_pipe_buffer: DEPTH=4 and DEPTH=1 instances share one stimulus stream,
// each with its own queue-based reference model and output monitor.
module tb_stage3_pipe_buffer;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int D  = (g == 0) ? 4 : 1;
      localparam int CW = $clog2(D + 1);

      logic          in_ready;
      logic          out_valid;
      logic [31:0]   out_data;
      logic [CW-1:0] count;
      logic          full;
      logic          empty;
      logic [31:0]   q [$];
      logic          m_ready;
      logic          m_valid;

      stage3_pipe_buffer #(.WIDTH(32), .DEPTH(D)) dut (
         .CLK       (CLK),
         .nRST      (nRST),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_data   (in_data),
         .in_ready  (in_ready),
         .out_valid (out_valid),
         .out_data  (out_data),
         .out_ready (out_ready),
         .count     (count),
         .full      (full),
         .empty     (empty)
      );

      // Reset is asynchronous: the model empties at once and outputs must follow without a clock.
      always @(negedge nRST) begin
         q.delete();
         #1;
         chk($sformatf("d%0d_rst_out_valid", D), 32'(out_valid), 32'd0);
         chk($sformatf("d%0d_rst_count", D), 32'(count), 32'd0);
         chk($sformatf("d%0d_rst_out_data", D), out_data, 32'd0);
      end

      // Monitor: compare against the model just before each rising edge, then advance the model.
      always begin
         @(negedge CLK);
         #2;
         m_valid = (q.size() != 0);
         m_ready = !flush && ((q.size() < D) || out_ready);
         chk($sformatf("d%0d_count", D), 32'(count), 32'(q.size()));
         chk($sformatf("d%0d_empty", D), 32'(empty), 32'(q.size() == 0));
         chk($sformatf("d%0d_full", D), 32'(full), 32'(q.size() == D));
         chk($sformatf("d%0d_out_valid", D), 32'(out_valid), 32'(m_valid));
         chk($sformatf("d%0d_in_ready", D), 32'(in_ready), 32'(m_ready));
         if (!nRST) begin
            chk($sformatf("d%0d_out_data_in_reset", D), out_data, 32'd0);
         end else if (m_valid) begin
            chk($sformatf("d%0d_out_data", D), out_data, q[0]);
         end
         if (nRST) begin
            if (flush) begin
               q.delete();
            end else begin
               if (m_valid && out_ready) void'(q.pop_front());
               if (in_valid && m_ready) q.push_back(in_data);
            end
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
      @(negedge CLK);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   initial begin
      nRST      = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEADBEEF;
      out_ready = 1'b0;
      repeat (3) @(negedge CLK);
      nRST = 1'b1;

      // Fill and stall, held fifth push, then drain in order.
      for (int k = 1; k <= 4; k++) drive(1'b1, 32'(k), 1'b0, 1'b0);
      drive(1'b1, 32'd5, 1'b0, 1'b0);
      drive(1'b1, 32'd5, 1'b0, 1'b0);
      drive(1'b1, 32'd5, 1'b1, 1'b0);
      repeat (6) drive(1'b0, 32'd0, 1'b1, 1'b0);

      // Push and pop in the same cycle while full.
      for (int k = 10; k <= 13; k++) drive(1'b1, 32'(k), 1'b0, 1'b0);
      drive(1'b1, 32'd14, 1'b1, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      repeat (5) drive(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush with three entries held and a push offered in the flush cycle.
      for (int k = 20; k <= 22; k++) drive(1'b1, 32'(k), 1'b0, 1'b0);
      drive(1'b1, 32'd7, 1'b0, 1'b1);
      repeat (3) drive(1'b0, 32'd0, 1'b1, 1'b0);

      // Streaming with a two-cycle stall after 105.
      for (int k = 100; k <= 105; k++) drive(1'b1, 32'(k), 1'b1, 1'b0);
      drive(1'b1, 32'd106, 1'b0, 1'b0);
      drive(1'b1, 32'd106, 1'b0, 1'b0);
      for (int k = 106; k <= 109; k++) drive(1'b1, 32'(k), 1'b1, 1'b0);
      repeat (5) drive(1'b0, 32'd0, 1'b1, 1'b0);

      // Reset pulse between edges with two entries held.
      drive(1'b1, 32'd30, 1'b0, 1'b0);
      drive(1'b1, 32'd31, 1'b0, 1'b0);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      #1 nRST = 1'b0;
      #3 nRST = 1'b1;
      for (int k = 40; k <= 42; k++) drive(1'b1, 32'(k), 1'b0, 1'b0);
      repeat (5) drive(1'b0, 32'd0, 1'b1, 1'b0);

      // Randomised traffic with occasional flushes.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 24) == 0));
      end
      repeat (8) drive(1'b0, 32'd0, 1'b1, 1'b0);

      @(negedge CLK);
      #4;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
